// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter unit for the fetch stage.
// Holds the PC and advances it by one per cycle. It also handles stall
// freezes, branch redirects, a latched interrupt vector jump, and a
// multi-beat PC restore that assembles a wide return address from a narrow
// bus, MSB beat first. All state changes on the falling edge of clk.
//
// Ports:
//   clk          clock (state updates on the falling edge)
//   Rst          synchronous active-high reset, overrides stall
//   stall        any bit high freezes all state (int_req is still latched)
//   hold         suppresses the increment only
//   branch_en    redirect request, target on branch_addr
//   int_req      interrupt request pulse, latched into int_pending
//   ret_start    begin a restore sequence
//   ret_valid    restore beat present on ret_data
//   ret_data     restore beat, MSB part first
//   pc           current program counter (registered)
//   int_pending  latched interrupt not yet taken
//   int_ack      one-cycle pulse in the cycle pc becomes INT_VECTOR
//   restore_busy high while a restore is in progress
module pc_sequencer #(
    parameter int unsigned          PC_WIDTH     = 32,
    parameter int unsigned          BUS_WIDTH    = 16,
    parameter int unsigned          NUM_STALL    = 2,
    parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32),
    parameter logic [PC_WIDTH-1:0]  INT_VECTOR   = PC_WIDTH'(0)
) (
    input  logic                  clk,
    input  logic                  Rst,
    input  logic [NUM_STALL-1:0]  stall,
    input  logic                  hold,
    input  logic                  branch_en,
    input  logic [PC_WIDTH-1:0]   branch_addr,
    input  logic                  int_req,
    input  logic                  ret_start,
    input  logic                  ret_valid,
    input  logic [BUS_WIDTH-1:0]  ret_data,
    output logic [PC_WIDTH-1:0]   pc,
    output logic                  int_pending,
    output logic                  int_ack,
    output logic                  restore_busy
);

    localparam int unsigned     BEATS    = PC_WIDTH / BUS_WIDTH;
    localparam int unsigned     CW       = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0]   LAST_IDX = CW'(BEATS - 1);

    typedef enum logic {
        IDLE,
        RESTORE
    } state_t;

    state_t                 state, state_next;
    logic [CW-1:0]          idx, idx_next;
    logic [PC_WIDTH-1:0]    pc_next;
    logic                   pending_next;
    logic                   ack_next;

    always_ff @(negedge clk) begin
        if (Rst) begin
            state       <= IDLE;
            idx         <= LAST_IDX;
            pc          <= RESET_VECTOR;
            int_pending <= 1'b0;
            int_ack     <= 1'b0;
        end else begin
            state       <= state_next;
            idx         <= idx_next;
            pc          <= pc_next;
            int_pending <= pending_next;
            int_ack     <= ack_next;
        end
    end

    always_comb begin
        state_next   = state;
        idx_next     = idx;
        pc_next      = pc;
        // Requests are latched unless an interrupt entry consumes them below;
        // this also covers the stalled case.
        pending_next = int_pending | int_req;
        ack_next     = 1'b0;

        if (stall == '0) begin
            case (state)
                IDLE: begin
                    if (int_pending || int_req) begin
                        pc_next      = INT_VECTOR;
                        ack_next     = 1'b1;
                        pending_next = 1'b0;
                    end else if (ret_start) begin
                        state_next = RESTORE;
                        idx_next   = LAST_IDX;
                    end else if (branch_en) begin
                        pc_next = branch_addr;
                    end else if (!hold) begin
                        pc_next = pc + PC_WIDTH'(1);
                    end
                end
                RESTORE: begin
                    if (ret_valid) begin
                        // Only the slice selected by idx is replaced, so
                        // partially restored values are visible on pc.
                        for (int unsigned b = 0; b < BEATS; b++) begin
                            if (idx == CW'(b)) begin
                                pc_next[b*BUS_WIDTH +: BUS_WIDTH] = ret_data;
                            end
                        end
                        if (idx == '0) begin
                            state_next = IDLE;
                            idx_next   = LAST_IDX;
                        end else begin
                            idx_next = idx - CW'(1);
                        end
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = LAST_IDX;
                end
            endcase
        end
    end

    assign restore_busy = (state == RESTORE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Testbench for pc_sequencer: directed scenarios followed by randomized
// stimulus, every cycle compared against a behavioural reference model.
module tb_pc_sequencer;

    localparam int unsigned PCW   = 32;
    localparam int unsigned BW    = 16;
    localparam int unsigned BEATS = PCW / BW;
    localparam longint unsigned RV   = 32;
    localparam longint unsigned IV   = 0;
    localparam longint unsigned MASK = 64'hFFFF_FFFF;
    localparam longint unsigned BMASK = 64'hFFFF;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      stall;
    logic            hold;
    logic            branch_en;
    logic [PCW-1:0]  branch_addr;
    logic            int_req;
    logic            ret_start;
    logic            ret_valid;
    logic [BW-1:0]   ret_data;
    logic [PCW-1:0]  pc;
    logic            int_pending;
    logic            int_ack;
    logic            restore_busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: plain integers, restore tracked as beats received.
    longint unsigned m_pc;
    bit              m_restoring;
    int              m_beats_done;
    bit              m_pending;
    bit              m_ack;

    pc_sequencer #(
        .PC_WIDTH     (PCW),
        .BUS_WIDTH    (BW),
        .NUM_STALL    (2),
        .RESET_VECTOR (32'd32),
        .INT_VECTOR   (32'd0)
    ) dut (
        .clk          (clk),
        .Rst          (rst),
        .stall        (stall),
        .hold         (hold),
        .branch_en    (branch_en),
        .branch_addr  (branch_addr),
        .int_req      (int_req),
        .ret_start    (ret_start),
        .ret_valid    (ret_valid),
        .ret_data     (ret_data),
        .pc           (pc),
        .int_pending  (int_pending),
        .int_ack      (int_ack),
        .restore_busy (restore_busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        rst = 1'b0; stall = '0; hold = 1'b0; branch_en = 1'b0; branch_addr = '0;
        int_req = 1'b0; ret_start = 1'b0; ret_valid = 1'b0; ret_data = '0;
    endtask

    // Apply one cycle of the specification's rules to the model.
    task automatic model_step();
        int pos;
        if (rst) begin
            m_pc = RV; m_restoring = 0; m_beats_done = 0; m_pending = 0; m_ack = 0;
        end else if (stall != 0) begin
            m_pending = m_pending | int_req;
            m_ack = 0;
        end else if (!m_restoring) begin
            m_ack = 0;
            if (m_pending || int_req) begin
                m_pc = IV; m_ack = 1; m_pending = 0;
            end else if (ret_start) begin
                m_restoring = 1; m_beats_done = 0;
            end else if (branch_en) begin
                m_pc = branch_addr;
            end else if (!hold) begin
                m_pc = (m_pc + 1) & MASK;
            end
        end else begin
            m_ack = 0;
            m_pending = m_pending | int_req;
            if (ret_valid) begin
                pos = int'(BEATS) - 1 - m_beats_done;
                m_pc = (m_pc & ~(BMASK << (pos * BW))) | (longint'(ret_data) << (pos * BW));
                m_pc = m_pc & MASK;
                m_beats_done++;
                if (m_beats_done == int'(BEATS)) m_restoring = 0;
            end
        end
    endtask

    // One clock: inputs already driven; DUT updates on the falling edge,
    // outputs are compared shortly after it.
    task automatic step(input string tag);
        @(negedge clk);
        #1;
        model_step();
        check_eq({tag, ".pc"},           64'(pc),     m_pc);
        check_eq({tag, ".int_pending"},  64'(int_pending), 64'(m_pending));
        check_eq({tag, ".int_ack"},      64'(int_ack),     64'(m_ack));
        check_eq({tag, ".restore_busy"}, 64'(restore_busy), 64'(m_restoring));
    endtask

    initial begin
        clear_inputs();
        m_pc = RV; m_restoring = 0; m_beats_done = 0; m_pending = 0; m_ack = 0;

        // Reset then free-run
        rst = 1'b1; step("reset");
        check_eq("reset_pc", 64'(pc), 64'd32);
        check_eq("reset_busy", 64'(restore_busy), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step("run");
        check_eq("run_pc35", 64'(pc), 64'd35);

        // Stall, branch, wrap
        branch_en = 1'b1; branch_addr = 32'd40; step("br40");
        branch_en = 1'b0; stall = 2'b10;
        step("stall1"); step("stall2");
        check_eq("stall_pc40", 64'(pc), 64'd40);
        stall = '0; branch_en = 1'b1; branch_addr = 32'hFFFF_FFFF; step("brmax");
        check_eq("br_max", 64'(pc), 64'hFFFF_FFFF);
        branch_en = 1'b0; step("wrap");
        check_eq("wrap_zero", 64'(pc), 64'd0);

        // Interrupt under stall, released together with a branch
        branch_en = 1'b1; branch_addr = 32'd7; step("br7");
        branch_en = 1'b0; stall = 2'b01; int_req = 1'b1; step("int_stall");
        check_eq("int_latched", 64'(int_pending), 64'd1);
        check_eq("int_frozen_pc", 64'(pc), 64'd7);
        int_req = 1'b0; stall = '0; branch_en = 1'b1; branch_addr = 32'h100; step("int_take");
        check_eq("int_vec_pc", 64'(pc), 64'd0);
        check_eq("int_ack_pulse", 64'(int_ack), 64'd1);
        branch_en = 1'b0; step("int_after");
        check_eq("int_ack_low", 64'(int_ack), 64'd0);

        // Restore with a gap
        branch_en = 1'b1; branch_addr = 32'd50; step("br50");
        branch_en = 1'b0; ret_start = 1'b1; step("rs_start");
        ret_start = 1'b0; ret_valid = 1'b1; ret_data = 16'h1234; step("rs_b1");
        check_eq("rs_partial", 64'(pc), 64'h1234_0032);
        ret_valid = 1'b0; step("rs_gap");
        ret_valid = 1'b1; ret_data = 16'hABCD; step("rs_b2");
        check_eq("rs_full", 64'(pc), 64'h1234_ABCD);
        check_eq("rs_busy_done", 64'(restore_busy), 64'd0);
        ret_valid = 1'b0; step("rs_inc");
        check_eq("rs_inc_pc", 64'(pc), 64'h1234_ABCE);

        // Interrupt deferred by restore
        ret_start = 1'b1; step("ri_start");
        ret_start = 1'b0; ret_valid = 1'b1; ret_data = 16'h5555; step("ri_b1");
        ret_valid = 1'b0; int_req = 1'b1; step("ri_req");
        check_eq("ri_pending", 64'(int_pending), 64'd1);
        int_req = 1'b0; ret_valid = 1'b1; ret_data = 16'h6666; step("ri_b2");
        check_eq("ri_no_vec", 64'(pc), 64'h5555_6666);
        ret_valid = 1'b0; step("ri_take");
        check_eq("ri_vec", 64'(pc), 64'd0);
        check_eq("ri_ack", 64'(int_ack), 64'd1);
        step("ri_after");

        // Reset mid-restore, then restart at the MSB beat
        ret_start = 1'b1; step("rr_start");
        ret_start = 1'b0; ret_valid = 1'b1; ret_data = 16'h9999; step("rr_b1");
        ret_valid = 1'b0; rst = 1'b1; step("rr_rst");
        check_eq("rr_pc", 64'(pc), 64'd32);
        check_eq("rr_busy", 64'(restore_busy), 64'd0);
        rst = 1'b0; ret_start = 1'b1; step("rr_restart");
        ret_start = 1'b0; ret_valid = 1'b1; ret_data = 16'hBEEF; step("rr_b1b");
        check_eq("rr_msb", 64'(pc), 64'hBEEF_0020);
        ret_valid = 1'b1; ret_data = 16'h0001; step("rr_b2b");

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 199) == 0);
            stall       = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            hold        = ($urandom_range(0, 3) == 0);
            branch_en   = ($urandom_range(0, 5) == 0);
            branch_addr = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFE : 32'($urandom);
            int_req     = ($urandom_range(0, 15) == 0);
            ret_start   = ($urandom_range(0, 7) == 0);
            ret_valid   = ($urandom_range(0, 1) == 1);
            ret_data    = 16'($urandom);
            step("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
